// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: row drive, 2-flop column sync, per-scan priority
// encode, scan-level debounce and committed key code with a held-level flag.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] colIn,
    output logic [3:0] rowOut,
    output logic [3:0] keyCode,
    output logic       keyHeld
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        SWAP
    } state_t;

    state_t state, stateNext;

    logic [3:0]       colMeta, colSync;
    logic [DIV_W-1:0] divCnt;
    logic [1:0]       rowIdx;
    logic             scanHit, candHit, evalDly;
    logic [3:0]       scanCode, candCode, matchCnt, codeNext;
    logic             rowHit, finalHit, sampleNow, resultMatch, commitReq;
    logic [1:0]       rowCol;
    logic [3:0]       finalCode;

    assign rowOut    = ~(4'b0001 << rowIdx);
    assign sampleNow = (divCnt == DIV_LAST);

    always_comb begin
        rowHit = 1'b0;
        rowCol = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!colSync[c] && !rowHit) begin
                rowHit = 1'b1;
                rowCol = 2'(c);
            end
        end
    end

    // Row 0 restarts the scan; later rows only fill in if nothing was found earlier.
    always_comb begin
        if (rowIdx != 2'd0 && scanHit) begin
            finalHit  = 1'b1;
            finalCode = scanCode;
        end else begin
            finalHit  = rowHit;
            finalCode = {rowIdx, rowCol};
        end
    end

    assign resultMatch = (finalHit == candHit) && (!finalHit || finalCode == candCode);

    always_ff @(posedge clk) begin
        if (rst) begin
            colMeta  <= '1;
            colSync  <= '1;
            divCnt   <= '0;
            rowIdx   <= '0;
            scanHit  <= 1'b0;
            scanCode <= '0;
            candHit  <= 1'b0;
            candCode <= '0;
            matchCnt <= '0;
            evalDly  <= 1'b0;
        end else begin
            colMeta <= colIn;
            colSync <= colMeta;
            evalDly <= 1'b0;
            if (sampleNow) begin
                divCnt   <= '0;
                rowIdx   <= rowIdx + 2'd1;
                scanHit  <= finalHit;
                scanCode <= finalCode;
                if (rowIdx == 2'd3) begin
                    evalDly <= 1'b1;
                    if (resultMatch) begin
                        if (matchCnt < CNT_MAX) begin
                            matchCnt <= matchCnt + 4'd1;
                        end
                    end else begin
                        candHit  <= finalHit;
                        candCode <= finalCode;
                        matchCnt <= 4'd1;
                    end
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

    // Committed key is implied by state: only HELD carries a key, so compare against that.
    always_comb begin
        case (state)
            HELD:    commitReq = evalDly && (matchCnt == CNT_MAX) && (!candHit || candCode != keyCode);
            IDLE:    commitReq = evalDly && (matchCnt == CNT_MAX) && candHit;
            default: commitReq = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = state;
        codeNext  = keyCode;
        case (state)
            IDLE: begin
                if (commitReq) begin
                    stateNext = HELD;
                    codeNext  = candCode;
                end
            end
            HELD: begin
                if (commitReq) begin
                    stateNext = candHit ? SWAP : IDLE;
                end
            end
            SWAP: begin
                stateNext = HELD;
                codeNext  = candCode;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            keyCode <= '0;
            keyHeld <= 1'b0;
        end else begin
            state   <= stateNext;
            keyCode <= codeNext;
            keyHeld <= (stateNext == HELD);
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench: keypad modelled from rowOut, scan-level reference model predicts
// every output change and the cycle it must appear on.
module tb_keypad_matrix_scanner;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] colIn;
    logic [3:0] rowOut;
    logic [3:0] keyCode;
    logic       keyHeld;

    logic [15:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        rstQ = 1'b1;

    typedef struct {
        int unsigned cyc;
        logic        held;
        logic [3:0]  code;
    } ev_t;

    ev_t  expQ[$];
    int   mCand, mCnt, mCommitted;
    logic [3:0] mLastCode;
    logic [4:0] prevOut = '0;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .colIn  (colIn),
        .rowOut (rowOut),
        .keyCode(keyCode),
        .keyHeld(keyHeld)
    );

    always #5 clk = ~clk;

    always_comb begin
        colIn = '1;
        for (int r = 0; r < 4; r++) begin
            if (rowOut == ~(4'b0001 << r)) begin
                for (int c = 0; c < 4; c++) colIn[c] = ~pressed[r*4+c];
            end
        end
    end

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rstQ <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int scanResult(input logic [15:0] s);
        for (int i = 0; i < 16; i++) if (s[i]) return i;
        return -1;
    endfunction

    // One full scan with a constant key set; commit lands one cycle after the row-3 sample.
    task automatic modelStep(input logic [15:0] s, input int unsigned e0);
        int r;
        r = scanResult(s);
        if (r == mCand) begin
            if (mCnt < DEB) mCnt++;
        end else begin
            mCand = r;
            mCnt  = 1;
        end
        if (mCnt == DEB && mCand != mCommitted) begin
            if (mCommitted < 0) begin
                expQ.push_back('{e0 + 17, 1'b1, 4'(mCand)});
            end else if (mCand < 0) begin
                expQ.push_back('{e0 + 17, 1'b0, mLastCode});
            end else begin
                expQ.push_back('{e0 + 17, 1'b0, mLastCode});
                expQ.push_back('{e0 + 18, 1'b1, 4'(mCand)});
            end
            mCommitted = mCand;
            if (mCand >= 0) mLastCode = 4'(mCand);
        end
    endtask

    always @(negedge clk) begin
        ev_t ev;
        checks++;
        if (!$onehot(~rowOut)) begin
            errors++;
            $display("FAIL row_onehot: actual %b required one low bit (cycle %0d)", rowOut, cyc);
        end
        if (rstQ) begin
            prevOut = {keyHeld, keyCode};
        end else begin
            if ({keyHeld, keyCode} !== prevOut) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: actual held=%0d code=%0d required no change (cycle %0d)",
                             keyHeld, keyCode, cyc);
                end else begin
                    ev = expQ.pop_front();
                    check("event_value", {27'd0, keyHeld, keyCode}, {27'd0, ev.held, ev.code});
                    check("event_cycle", cyc, ev.cyc);
                end
            end
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                ev = expQ.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: actual none required held=%0d code=%0d at cycle %0d",
                         ev.held, ev.code, ev.cyc);
            end
            prevOut = {keyHeld, keyCode};
        end
    end

    task automatic waitScanStart();
        logic [3:0] prev;
        prev = rowOut;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rowOut == 4'b1110 && prev == 4'b0111) return;
            prev = rowOut;
        end
        checks++;
        errors++;
        $display("FAIL scan_start: actual timeout required row wrap within 40 cycles");
    endtask

    task automatic runScan(input logic [15:0] s);
        pressed = s;
        modelStep(s, cyc);
        waitScanStart();
    endtask

    // Leaves the bench on the negedge where the first post-reset scan begins.
    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("reset_rowOut", {28'd0, rowOut}, 32'b1110);
        check("reset_keyHeld", {31'd0, keyHeld}, 32'd0);
        check("reset_keyCode", {28'd0, keyCode}, 32'd0);
        expQ.delete();
        mCand      = -1;
        mCnt       = 0;
        mCommitted = -1;
        mLastCode  = '0;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] lastSet;
        int kind;

        doReset(2);
        pressed = '0;
        modelStep('0, cyc);
        repeat (4) @(negedge clk);
        check("row_advance", {28'd0, rowOut}, 32'b1101);
        waitScanStart();

        repeat (5) runScan(16'd1 << 9);
        check("press_code", {28'd0, keyCode}, 32'd9);
        check("press_held", {31'd0, keyHeld}, 32'd1);
        repeat (4) runScan('0);
        check("release_held", {31'd0, keyHeld}, 32'd0);

        repeat (2) runScan(16'd1 << 7);
        runScan('0);
        repeat (2) runScan(16'd1 << 7);
        repeat (4) runScan('0);
        check("bounce_code", {28'd0, keyCode}, 32'd9);

        repeat (4) runScan((16'd1 << 2) | (16'd1 << 15));
        check("multi_code", {28'd0, keyCode}, 32'd2);
        repeat (4) runScan(16'd1 << 15);
        check("swap_code", {28'd0, keyCode}, 32'd15);
        check("swap_held", {31'd0, keyHeld}, 32'd1);
        repeat (4) runScan('0);

        lastSet = '0;
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       s = '0;
                1:       s = 16'd1 << $urandom_range(0, 15);
                2:       s = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                default: s = lastSet;
            endcase
            lastSet = s;
            repeat ($urandom_range(1, 5)) runScan(s);
        end
        repeat (4) runScan('0);

        runScan(16'd1 << 6);
        runScan(16'd1 << 6);
        repeat (16) @(negedge clk);
        doReset(1);
        repeat (4) runScan(16'd1 << 6);
        check("rerun_code", {28'd0, keyCode}, 32'd6);
        check("rerun_held", {31'd0, keyHeld}, 32'd1);
        repeat (4) runScan('0);

        repeat (3) @(negedge clk);
        check("queue_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
